// File: rtl/fir_pkg.sv
// +-------------------------------------------------------------------+
// | fir_pkg : shared constants and beat type for the FIR output stage |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package fir_pkg;

   localparam int OUT_WIDTH      = 16;
   localparam int FRAC_SHIFT     = 15;
   localparam int OUT_FIFO_DEPTH = 16;

   typedef struct packed {
      logic signed [OUT_WIDTH-1:0] data;
      logic                        last;
      logic                        sat;
      logic                        err;
   } out_beat_t;

endpackage

`default_nettype wire

// File: rtl/fir_sync_fifo.sv
// +-------------------------------------------------------------------+
// | fir_sync_fifo : first-word-fall-through FIFO of out_beat_t        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module fir_sync_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = OUT_FIFO_DEPTH
)
(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  out_beat_t                  din_i,
   input  logic                       pop_i,
   output out_beat_t                  dout_o,
   output logic                       empty_o,
   output logic                       accept_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   out_beat_t        mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      level_q;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full   = (level_q == (AW+1)'(DEPTH));
   assign w_pop    = pop_i && (level_q != '0);
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_push   = push_i && (!w_full || w_pop);
   assign accept_o = w_push;
   assign empty_o  = (level_q == '0);
   assign level_o  = level_q;
   assign dout_o   = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (w_push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (w_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         level_q <= level_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/fir_output_stream.sv
// +-------------------------------------------------------------------+
// | fir_output_stream : round/saturate, frame and stream FIR results  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module fir_output_stream
   import fir_pkg::*;
#(
   parameter int IN_WIDTH    = 40,
   parameter int FIFO_DEPTH  = OUT_FIFO_DEPTH,
   parameter int FRAME_LEN_W = 16
)
(
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           enable,
   input  logic                           clear,
   input  logic [FRAME_LEN_W-1:0]         frame_len,
   input  logic                           output_data_valid,
   input  logic [IN_WIDTH-1:0]            output_data,
   input  logic                           error,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [OUT_WIDTH-1:0]           m_axis_tdata,
   output logic                           m_axis_tlast,
   output logic [1:0]                     m_axis_tuser,
   output logic                           overflow_sticky,
   output logic [15:0]                    drop_count,
   output logic [15:0]                    sat_count,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

   localparam logic signed [IN_WIDTH:0] c_half = (IN_WIDTH+1)'(1) << (FRAC_SHIFT-1);
   localparam logic signed [IN_WIDTH:0] c_max  = (IN_WIDTH+1)'((2**(OUT_WIDTH-1))-1);
   localparam logic signed [IN_WIDTH:0] c_min  = ~c_max;

   logic signed [IN_WIDTH:0]    w_sum;
   logic signed [IN_WIDTH:0]    w_shift;
   logic signed [OUT_WIDTH-1:0] q_data_d;
   logic                        q_sat_d;

   logic                        q_valid_q;
   logic signed [OUT_WIDTH-1:0] q_data_q;
   logic                        q_sat_q;
   logic                        q_err_q;

   logic [FRAME_LEN_W-1:0]      len_q;
   logic [FRAME_LEN_W-1:0]      pos_q;
   logic [FRAME_LEN_W-1:0]      w_len;
   logic                        w_last;
   logic                        w_accept;
   logic                        w_empty;
   out_beat_t                   w_in_beat;
   out_beat_t                   w_out_beat;

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      w_sum   = $signed({output_data[IN_WIDTH-1], output_data}) + c_half;
      w_shift = w_sum >>> FRAC_SHIFT;
      q_sat_d = 1'b0;
      if (w_shift > c_max) begin
         q_data_d = c_max[OUT_WIDTH-1:0];
         q_sat_d  = 1'b1;
      end else if (w_shift < c_min) begin
         q_data_d = c_min[OUT_WIDTH-1:0];
         q_sat_d  = 1'b1;
      end else begin
         q_data_d = w_shift[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         q_valid_q <= 1'b0;
         q_data_q  <= '0;
         q_sat_q   <= 1'b0;
         q_err_q   <= 1'b0;
      end else begin
         q_valid_q <= output_data_valid && enable;
         if (output_data_valid && enable) begin
            q_data_q <= q_data_d;
            q_sat_q  <= q_sat_d;
            q_err_q  <= error;
         end
      end
   end

   // A new frame picks up frame_len live; mid-frame the latched length rules.
   assign w_len  = (pos_q == '0) ? frame_len : len_q;
   assign w_last = (w_len != '0) && (pos_q == (w_len - FRAME_LEN_W'(1)));

   always_comb begin
      w_in_beat      = '0;
      w_in_beat.data = q_data_q;
      w_in_beat.last = w_last;
      w_in_beat.sat  = q_sat_q;
      w_in_beat.err  = q_err_q;
   end

   fir_sync_fifo #(
      .DEPTH    (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .flush_i  (clear),
      .push_i   (q_valid_q),
      .din_i    (w_in_beat),
      .pop_i    (m_axis_tready),
      .dout_o   (w_out_beat),
      .empty_o  (w_empty),
      .accept_o (w_accept),
      .level_o  (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         len_q           <= '0;
         pos_q           <= '0;
         overflow_sticky <= 1'b0;
         drop_count      <= '0;
         sat_count       <= '0;
      end else if (q_valid_q) begin
         if (w_accept) begin
            if (pos_q == '0) begin
               len_q <= frame_len;
            end
            pos_q <= (w_last || (w_len == '0)) ? '0 : pos_q + FRAME_LEN_W'(1);
            if (q_sat_q && (sat_count != 16'hFFFF)) begin
               sat_count <= sat_count + 16'd1;
            end
         end else begin
            overflow_sticky <= 1'b1;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end
      end
   end

   assign m_axis_tvalid = !w_empty;
   assign m_axis_tdata  = w_out_beat.data;
   assign m_axis_tlast  = w_out_beat.last;
   assign m_axis_tuser  = {w_out_beat.err, w_out_beat.sat};

endmodule

`default_nettype wire

// File: tb/tb_fir_output_stream.sv
// +-------------------------------------------------------------------+
// | tb_fir_output_stream : scoreboard bench for fir_output_stream     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fir_output_stream;
   import fir_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic        clear;
   logic [15:0] frame_len;
   logic        valid_in;
   logic [39:0] data_in;
   logic        err_in;
   logic        tvalid;
   logic        tready;
   logic [15:0] tdata;
   logic        tlast;
   logic [1:0]  tuser;
   logic        sticky;
   logic [15:0] drop_cnt;
   logic [15:0] sat_cnt;
   logic [4:0]  level;

   always #5 clk = ~clk;

   fir_output_stream dut (
      .clk               (clk),
      .rstn              (rstn),
      .enable            (enable),
      .clear             (clear),
      .frame_len         (frame_len),
      .output_data_valid (valid_in),
      .output_data       (data_in),
      .error             (err_in),
      .m_axis_tvalid     (tvalid),
      .m_axis_tready     (tready),
      .m_axis_tdata      (tdata),
      .m_axis_tlast      (tlast),
      .m_axis_tuser      (tuser),
      .overflow_sticky   (sticky),
      .drop_count        (drop_cnt),
      .sat_count         (sat_cnt),
      .fifo_level        (level)
   );

   int        n_checks = 0;
   int        n_pass   = 0;
   int        n_last   = 0;
   int        mlen     = 0;
   int        mpos     = 0;
   out_beat_t sb[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] req);
      n_checks++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, req);
   endtask

   // Drives one result for a cycle and predicts the beat it should become.
   task automatic send(input logic [39:0] raw, input logic e, input bit drop);
      longint    xs;
      longint    q;
      out_beat_t b;
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = raw;
      err_in   = e;
      if (enable && !drop) begin
         xs = {{24{raw[39]}}, raw};
         q  = (xs + 64'sd16384) >>> 15;
         b  = '0;
         if (q > 32767)       begin b.data = 16'h7FFF; b.sat = 1'b1; end
         else if (q < -32768) begin b.data = 16'h8000; b.sat = 1'b1; end
         else                 b.data = q[15:0];
         b.err = e;
         if (mpos == 0) mlen = int'(frame_len);
         b.last = (mlen != 0) && (mpos == mlen - 1);
         mpos   = (b.last || mlen == 0) ? 0 : mpos + 1;
         sb.push_back(b);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      valid_in = 1'b0;
      err_in   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || tvalid) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("drain_done", 64'(sb.size() == 0 && !tvalid), 64'd1);
   endtask

   always @(negedge clk) begin
      out_beat_t eb;
      if (tvalid && tready) begin
         check_eq("sb_has_beat", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            eb = sb.pop_front();
            check_eq("tdata", 64'(tdata), 64'($unsigned(eb.data)));
            check_eq("tlast", 64'(tlast), 64'(eb.last));
            check_eq("tuser", 64'(tuser), 64'({eb.err, eb.sat}));
            if (tlast) n_last++;
         end
      end else if (tvalid && sb.size() != 0) begin
         check_eq("stall_tdata", 64'(tdata), 64'($unsigned(sb[0].data)));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lasts0;
      rstn = 1'b0; enable = 1'b1; clear = 1'b0; frame_len = 16'd0;
      valid_in = 1'b0; data_in = '0; err_in = 1'b0; tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tvalid", 64'(tvalid), 64'd0);
      check_eq("rst_level", 64'(level), 64'd0);
      check_eq("rst_tdata", 64'(tdata), 64'd0);
      check_eq("rst_counts", 64'({sticky, drop_cnt, sat_cnt}), 64'd0);
      @(posedge clk); #1 rstn = 1'b1;

      // Rounding
      send(40'h00_0000_8000, 1'b0, 1'b0);
      send(40'h00_0000_4000, 1'b0, 1'b0);
      send(40'h00_0000_3FFF, 1'b0, 1'b0);
      send(40'hFF_FFFF_C000, 1'b0, 1'b0);
      send(40'h00_0001_0000, 1'b1, 1'b0);
      idle();
      wait_drain(50);

      // Saturation
      send(40'h7F_FFFF_FFFF, 1'b0, 1'b0);
      send(40'h80_0000_0000, 1'b0, 1'b0);
      send(40'hFF_FFF0_0000, 1'b0, 1'b0);
      idle();
      wait_drain(50);
      check_eq("sat_count", 64'(sat_cnt), 64'd2);
      check_eq("drop_none", 64'(drop_cnt), 64'd0);

      // Disabled input is ignored
      enable = 1'b0;
      for (int i = 0; i < 3; i++) send(40'(i + 1) << 15, 1'b0, 1'b0);
      idle();
      repeat (4) @(posedge clk);
      #1;
      check_eq("dis_level", 64'(level), 64'd0);
      enable = 1'b1;

      // Backpressure overflow
      tready = 1'b0;
      for (int i = 0; i < 20; i++) send(40'(i) << 15, 1'b0, i >= 16);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check_eq("bp_level", 64'(level), 64'd16);
      check_eq("bp_drop", 64'(drop_cnt), 64'd4);
      check_eq("bp_sticky", 64'(sticky), 64'd1);
      tready = 1'b1;
      wait_drain(100);

      // Full with simultaneous pop
      tready = 1'b0;
      for (int i = 0; i < 16; i++) send((40'(i) << 15) + 40'd100, 1'b0, 1'b0);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check_eq("full_level", 64'(level), 64'd16);
      for (int i = 0; i < 20; i++) begin
         send(40'(i + 300) << 15, 1'b0, 1'b0);
         if (i == 1) tready = 1'b1;
         if (i >= 1) check_eq("full_pop_level", 64'(level), 64'd16);
      end
      idle();
      wait_drain(100);
      check_eq("full_pop_drop", 64'(drop_cnt), 64'd4);

      // Framing, with a length change taking effect at the next frame
      lasts0    = n_last;
      frame_len = 16'd4;
      for (int i = 0; i < 5; i++) send(40'(i) << 15, 1'b0, 1'b0);
      idle();
      wait_drain(50);
      frame_len = 16'd3;
      for (int i = 5; i < 11; i++) send(40'(i) << 15, 1'b0, 1'b0);
      idle();
      wait_drain(50);
      check_eq("frame_lasts", 64'(n_last - lasts0), 64'd3);
      frame_len = 16'd0;
      for (int i = 0; i < 6; i++) send(40'(i) << 15, 1'b0, 1'b0);
      idle();
      wait_drain(50);
      check_eq("nolen_lasts", 64'(n_last - lasts0), 64'd3);

      // clear mid-stream
      frame_len = 16'd3;
      tready    = 1'b0;
      for (int i = 0; i < 8; i++) send(40'(i + 50) << 15, 1'b0, 1'b0);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check_eq("pre_clr_level", 64'(level), 64'd8);
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      sb.delete();
      mpos = 0;
      check_eq("clr_tvalid", 64'(tvalid), 64'd0);
      check_eq("clr_level", 64'(level), 64'd0);
      check_eq("clr_counts", 64'({sticky, drop_cnt, sat_cnt}), 64'd0);
      tready = 1'b1;
      lasts0 = n_last;
      for (int i = 0; i < 3; i++) send(40'(i + 70) << 15, 1'b0, 1'b0);
      idle();
      wait_drain(50);
      check_eq("clr_frame_last", 64'(n_last - lasts0), 64'd1);

      // rstn mid-stream
      tready = 1'b0;
      for (int i = 0; i < 5; i++) send(40'(i + 90) << 15, 1'b0, 1'b0);
      idle();
      repeat (2) @(posedge clk);
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      sb.delete();
      mpos = 0;
      check_eq("rstn_tvalid", 64'(tvalid), 64'd0);
      check_eq("rstn_level", 64'(level), 64'd0);
      tready = 1'b1;
      lasts0 = n_last;
      for (int i = 0; i < 3; i++) send(40'(i + 110) << 15, 1'b0, 1'b0);
      idle();
      wait_drain(50);
      check_eq("rstn_frame_last", 64'(n_last - lasts0), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
